// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: queues (op, A, B) commands in a small FIFO, issues them one
// at a time to the 4-unit ALU datapath, waits a fixed latency, then returns the
// selected unit's result over a valid/ready handshake.
// Optional build macro: ALU_SEQ_STATS_EN adds saturating per-op result counters
// (stat_xnor/stat_shift/stat_add/stat_mult) and the stat_clr input.
module alu_op_sequencer #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_a,
  input  logic [2:0] cmd_b,
  output logic [1:0] alu_op,
  output logic [2:0] alu_a,
  output logic [2:0] alu_b,
  output logic       alu_en,
  output logic       alu_rst_n,
  input  logic [5:0] alu_doutxnor,
  input  logic [5:0] alu_doutshift,
  input  logic [5:0] alu_doutadd,
  input  logic       alu_c,
  input  logic [5:0] alu_doutmult,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [1:0] res_op,
  output logic [5:0] res_data,
  output logic       res_carry,
  output logic       busy
`ifdef ALU_SEQ_STATS_EN
  ,
  input  logic       stat_clr,
  output logic [7:0] stat_xnor,
  output logic [7:0] stat_shift,
  output logic [7:0] stat_add,
  output logic [7:0] stat_mult
`endif
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = PW + 1;
  localparam int LW   = $clog2(LATENCY + 1);

  localparam logic [CNTW-1:0] FULL_C = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] ZERO_C = {CNTW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Each FIFO entry packs {op[1:0], a[2:0], b[2:0]}.
  logic [7:0]      fifo_mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CNTW-1:0] count_r;
  state_t          state_r;
  state_t          state_nx_s;
  logic [LW-1:0]   lat_cnt_r;
  logic            push_s;
  logic            pop_s;
  logic [5:0]      sel_data_s;
  logic            sel_carry_s;

  // FIFO handshake: push from the requester, pop only when the FSM issues from IDLE.
  always_comb begin
    push_s = cmd_valid && cmd_ready;
    pop_s  = (state_r == ST_IDLE) && (count_r != ZERO_C);
  end

  // Status outputs derived from registered state only (no same-cycle pass-through).
  always_comb begin
    cmd_ready = (count_r != FULL_C);
    busy      = (state_r != ST_IDLE) || (count_r != ZERO_C);
    alu_rst_n = ~rst;
  end

  // Result mux: pick the unit that matches the op currently held on the ALU bus.
  always_comb begin
    sel_data_s  = 6'd0;
    sel_carry_s = 1'b0;
    case (alu_op)
      2'b00: sel_data_s = alu_doutxnor;
      2'b01: sel_data_s = alu_doutshift;
      2'b10: begin
        sel_data_s  = alu_doutadd;
        sel_carry_s = alu_c;
      end
      2'b11: sel_data_s = alu_doutmult;
      default: begin
        sel_data_s  = 6'd0;
        sel_carry_s = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (count_r != ZERO_C) state_nx_s = ST_WAIT;
        else                   state_nx_s = ST_IDLE;
      end
      ST_WAIT: begin
        if (lat_cnt_r == LW'(1)) state_nx_s = ST_DONE;
        else                     state_nx_s = ST_WAIT;
      end
      ST_DONE: begin
        if (res_valid && res_ready) state_nx_s = ST_IDLE;
        else                        state_nx_s = ST_DONE;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FIFO storage; contents are don't-care until written, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {cmd_op, cmd_a, cmd_b};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= ZERO_C;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNTW'(1);
        2'b01:   count_r <= count_r - CNTW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Issue, latency countdown and result capture; all ALU and result outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op    <= 2'd0;
      alu_a     <= 3'd0;
      alu_b     <= 3'd0;
      alu_en    <= 1'b0;
      lat_cnt_r <= {LW{1'b0}};
      res_valid <= 1'b0;
      res_op    <= 2'd0;
      res_data  <= 6'd0;
      res_carry <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            {alu_op, alu_a, alu_b} <= fifo_mem_r[rd_ptr_r];
            alu_en    <= 1'b1;
            lat_cnt_r <= LW'(LATENCY);
          end
        end
        ST_WAIT: begin
          lat_cnt_r <= lat_cnt_r - LW'(1);
          if (lat_cnt_r == LW'(1)) begin
            alu_en    <= 1'b0;
            res_valid <= 1'b1;
            res_op    <= alu_op;
            res_data  <= sel_data_s;
            res_carry <= sel_carry_s;
          end
        end
        ST_DONE: begin
          if (res_ready) res_valid <= 1'b0;
        end
        default: begin
          alu_en    <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  logic handshake_s;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A result handshake is what each per-op counter tallies.
  always_comb begin
    handshake_s = (state_r == ST_DONE) && res_valid && res_ready;
  end

  // Saturating per-op counters; a clear in the same cycle as a handshake wins.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_xnor  <= 8'd0;
      stat_shift <= 8'd0;
      stat_add   <= 8'd0;
      stat_mult  <= 8'd0;
    end else if (handshake_s) begin
      case (res_op)
        2'b00:   stat_xnor  <= sat_inc(stat_xnor);
        2'b01:   stat_shift <= sat_inc(stat_shift);
        2'b10:   stat_add   <= sat_inc(stat_add);
        2'b11:   stat_mult  <= sat_inc(stat_mult);
        default: stat_xnor  <= stat_xnor;
      endcase
    end
  end
`endif

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Command scheduler for the 4-unit 3-bit ALU datapath: xnor, shift, add and multiply, each with registered 6-bit outputs.
- Queues (op, A, B) commands from a requester in a small FIFO.
- Issues one command at a time to the ALU units and holds enable for a fixed latency.
- Captures the selected unit's result and returns it over a valid/ready handshake.
- Sits between a command source (test controller or UART front-end) and the ALU units.

Parameters:
DEPTH, 4, command FIFO depth in entries; power of 2, >= 2.
LATENCY, 2, cycles from ALU operand load to a valid unit output; >= 1.

Ports:
clk  in  1  system clock (CLK_50 at top level)
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept a command
cmd_op  in  2  00 xnor, 01 shift, 10 add, 11 mult
cmd_a  in  3  operand A
cmd_b  in  3  operand B
alu_op  out  2  op driven to all ALU units
alu_a  out  3  operand A to the ALU
alu_b  out  3  operand B to the ALU
alu_en  out  1  enable to the ALU units
alu_rst_n  out  1  active-low reset to the ALU units; = ~rst, combinational
alu_doutxnor  in  6  xnor unit result
alu_doutshift  in  6  shift unit result
alu_doutadd  in  6  add unit result
alu_c  in  1  add unit carry
alu_doutmult  in  6  multiply unit result
res_valid  out  1  result held
res_ready  in  1  consumer accepts the result
res_op  out  2  op of the returned result
res_data  out  6  result
res_carry  out  1  alu_c for add; 0 for all other ops
busy  out  1  state != IDLE or FIFO not empty

Behaviour:
- Reset is synchronous and active-high, sampled on the rising edge of clk. On reset:
  - FIFO is emptied, FSM goes to IDLE, wait counter = 0.
  - alu_op/alu_a/alu_b/alu_en = 0.
  - res_valid/res_op/res_data/res_carry = 0.
  - cmd_ready = 1 once rst deasserts.
- A reset asserted mid-operation aborts the in-flight command and discards all queued commands. No result is produced for them.
- FIFO:
  - Push on cmd_valid && cmd_ready. cmd_ready = (count != DEPTH), computed from registered count only; no same-cycle pass-through.
  - Pop and push in the same cycle are both allowed, and count is unchanged.
  - A push while full is ignored (cmd_ready is 0); the FIFO is not corrupted.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: if count > 0, at the edge:
    - pop the head and load alu_op/alu_a/alu_b from it;
    - set alu_en = 1 and cnt = LATENCY;
    - go to WAIT.
  - WAIT: alu_en stays 1 and operands are held stable. Each edge decrements cnt.
    - At the edge where cnt == 1: capture the result, set res_valid = 1, alu_en = 0, and go to DONE.
  - Result select by alu_op: 00 doutxnor, 01 doutshift, 10 doutadd with res_carry = alu_c, 11 doutmult.
  - DONE: res_op/res_data/res_carry are held until res_valid && res_ready. At that edge res_valid = 0 and the FSM goes to IDLE. The next issue follows one cycle later (1-cycle bubble).
  - res_ready while res_valid = 0 has no effect.
- Latency: with an empty FIFO and IDLE, a command accepted at edge E0 yields alu_en rising at E1 and res_valid rising at E(LATENCY+1).
- Throughput: one command per LATENCY+2 cycles with res_ready held high.
- The FIFO keeps accepting commands during WAIT/DONE up to DEPTH.
- Commands complete strictly in FIFO order.

Optional Feature:
ALU_SEQ_STATS_EN.
- Defined: adds outputs stat_xnor, stat_shift, stat_add and stat_mult, 8 bits each.
  - Each counts result handshakes for its op and saturates at 255.
  - Cleared by rst.
  - Adds input stat_clr (1 bit), a synchronous clear of all four counters. If stat_clr and a handshake occur in the same cycle, clear wins.
- Undefined: none of these ports or counters exist; all other behaviour is identical.

Test Plan:
- Stub ALU drives doutxnor=6'h11, doutshift=6'h22, doutadd=6'h08 with c=1, doutmult=6'h31. Issue ops 00,01,10,11 -> res_data 11,22,08,31 in order. res_carry is 1 only for op 10. res_op matches each command.
- Single add A=3, B=5 accepted at E0, LATENCY=2, res_ready=1 -> alu_en high E1..E3, res_valid high after E3. alu_a=3 and alu_b=5 stable throughout WAIT.
- Push 5 commands back-to-back with res_ready=0 -> first result held in DONE. cmd_ready falls after 4 queued (the 5th accepted only after the first pop). cmd_valid asserted while full is ignored.
- Hold res_ready low 10 cycles in DONE -> res_data, res_op and res_carry remain stable and no further ALU issue occurs. Raising res_ready completes the handshake, and the next issue follows 1 cycle later.
- Assert rst for 1 cycle during WAIT with 2 commands queued -> res_valid=0, alu_en=0, cmd_ready=1, busy=0 after the edge. No result ever appears for the aborted commands.
- With ALU_SEQ_STATS_EN: 3 adds and 1 mult -> stat_add=3 and stat_mult=1. 300 xnors -> stat_xnor=255. stat_clr -> all 0.
